// File: rtl/ycrcb2rgb.sv
// BT.601 full-range YCbCr -> RGB, 3-stage valid/ready pipeline, Q14 coefficients.
// Optional clamp counter on sat_count is built when YCRCB2RGB_SAT_COUNT_EN is defined.
module ycrcb2rgb (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data,
  output logic [15:0] sat_count
);

  localparam logic signed [24:0] KR  = 25'sd22970;
  localparam logic signed [24:0] KGB = 25'sd5638;
  localparam logic signed [24:0] KGR = 25'sd11700;
  localparam logic signed [24:0] KB  = 25'sd29032;

  logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic               rdy1, rdy2, rdy3;
  logic [7:0]         y1_q, y1_d;
  logic signed [8:0]  cb1_q, cb1_d, cr1_q, cr1_d;
  logic signed [24:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic [23:0]        rgb3_q, rgb3_d;
  logic signed [24:0] y_sc, cb_x, cr_x;

  function automatic logic signed [24:0] round_q14(input logic signed [24:0] s);
    round_q14 = (s + 25'sd8192) >>> 14;
  endfunction

  function automatic logic [7:0] round_clamp(input logic signed [24:0] s);
    logic signed [24:0] q;
    q = round_q14(s);
    if (q < 0)
      round_clamp = 8'd0;
    else if (q > 25'sd255)
      round_clamp = 8'd255;
    else
      round_clamp = q[7:0];
  endfunction

  // A stage may load whenever it is empty or its successor is moving.
  always_comb begin
    rdy3 = !v3_q || out_ready;
    rdy2 = !v2_q || rdy3;
    rdy1 = !v1_q || rdy2;
  end

  assign in_ready  = rdy1;
  assign out_valid = v3_q;
  assign out_data  = rgb3_q;

  always_comb begin
    v1_d   = v1_q;
    y1_d   = y1_q;
    cb1_d  = cb1_q;
    cr1_d  = cr1_q;
    v2_d   = v2_q;
    r2_d   = r2_q;
    g2_d   = g2_q;
    b2_d   = b2_q;
    v3_d   = v3_q;
    rgb3_d = rgb3_q;
    y_sc   = $signed({3'b000, y1_q, 14'd0});
    cb_x   = {{16{cb1_q[8]}}, cb1_q};
    cr_x   = {{16{cr1_q[8]}}, cr1_q};

    if (rdy1) begin
      v1_d = in_valid;
      if (in_valid) begin
        y1_d  = in_data[7:0];
        cb1_d = $signed({1'b0, in_data[15:8]}) - 9'sd128;
        cr1_d = $signed({1'b0, in_data[23:16]}) - 9'sd128;
      end
    end

    if (rdy2) begin
      v2_d = v1_q;
      if (v1_q) begin
        r2_d = y_sc + KR * cr_x;
        g2_d = y_sc - KGB * cb_x - KGR * cr_x;
        b2_d = y_sc + KB * cb_x;
      end
    end

    if (rdy3) begin
      v3_d = v2_q;
      if (v2_q)
        rgb3_d = {round_clamp(b2_q), round_clamp(g2_q), round_clamp(r2_q)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      y1_q   <= '0;
      cb1_q  <= '0;
      cr1_q  <= '0;
      r2_q   <= '0;
      g2_q   <= '0;
      b2_q   <= '0;
      rgb3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      y1_q   <= y1_d;
      cb1_q  <= cb1_d;
      cr1_q  <= cr1_d;
      r2_q   <= r2_d;
      g2_q   <= g2_d;
      b2_q   <= b2_d;
      rgb3_q <= rgb3_d;
    end
  end

`ifdef YCRCB2RGB_SAT_COUNT_EN
  logic [1:0]  sat3_q, sat3_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [16:0] sat_sum;

  function automatic logic clamped(input logic signed [24:0] s);
    logic signed [24:0] q;
    q = round_q14(s);
    clamped = (q < 0) || (q > 25'sd255);
  endfunction

  // The clamp count travels with its beat so it is charged only when the beat leaves.
  always_comb begin
    sat3_d    = sat3_q;
    sat_cnt_d = sat_cnt_q;
    sat_sum   = {1'b0, sat_cnt_q} + {15'd0, sat3_q};
    if (rdy3 && v2_q)
      sat3_d = {1'b0, clamped(r2_q)} + {1'b0, clamped(g2_q)} + {1'b0, clamped(b2_q)};
    if (v3_q && out_ready)
      sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat3_q    <= '0;
      sat_cnt_q <= '0;
    end else begin
      sat3_q    <= sat3_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ycrcb2rgb.sv
// Self-checking bench for ycrcb2rgb: real-valued reference model, scoreboard queue,
// directed corner beats, backpressure, mid-stream reset and a randomized stream.
module tb_ycrcb2rgb;

`ifdef YCRCB2RGB_SAT_COUNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [15:0] sat_count;

  int total = 0;
  int bad   = 0;

  logic [25:0] exp_q[$];
  logic [15:0] sat_exp;
  logic        stall_q;
  logic [23:0] stall_data;
  int          out_xfers;
  bit          rand_run;

  ycrcb2rgb dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rnd(input real v);
    return $rtoi($floor(v + 0.5));
  endfunction

  // Returns {clamp_count[1:0], B, G, R} for {Cr, Cb, Y}.
  function automatic logic [25:0] model(input logic [23:0] d);
    real y, cb, cr;
    int  c[3];
    int  n;
    logic [7:0] o[3];
    y  = real'(int'(d[7:0]));
    cb = real'(int'(d[15:8])) - 128.0;
    cr = real'(int'(d[23:16])) - 128.0;
    c[0] = rnd((y * 16384.0 + 22970.0 * cr) / 16384.0);
    c[1] = rnd((y * 16384.0 - 5638.0 * cb - 11700.0 * cr) / 16384.0);
    c[2] = rnd((y * 16384.0 + 29032.0 * cb) / 16384.0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (c[i] < 0) begin o[i] = 8'd0; n++; end
      else if (c[i] > 255) begin o[i] = 8'd255; n++; end
      else o[i] = 8'(c[i]);
    end
    return {2'(n), o[2], o[1], o[0]};
  endfunction

  // Predicts the transfers of the coming rising edge from settled mid-cycle values.
  always @(negedge clk) begin
    logic [25:0] e;
    logic [16:0] s;
    #2;
    if (!rst) begin
      if (stall_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, stall_data);
      end
      chk("sat_count", sat_count, sat_exp);
      if (out_valid && exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_beat: got out_valid=1 with data %0h expected no beat", out_data);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[23:0]);
        s = {1'b0, sat_exp} + {15'd0, e[25:24]};
        if (SAT_EN) sat_exp = s[16] ? 16'hFFFF : s[15:0];
        out_xfers++;
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
    end
  end

  task automatic clear_model();
    exp_q.delete();
    sat_exp = '0;
    stall_q = 1'b0;
  endtask

  task automatic send(input logic [23:0] d);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    k = 0;
    while (!in_ready && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k == 1000) begin
      $display("FAIL send_timeout: got in_ready=0 expected acceptance");
      $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
      $fatal(1, "send timeout");
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 24'($urandom);
    end
  endtask

  // Counts rising edges from the accepting edge (inclusive) until out_valid is seen.
  task automatic lat_beat(input logic [23:0] d, input logic [23:0] expo);
    int n;
    bit got;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    #1;
    chk("lat_in_ready", in_ready, 1);
    n = 0;
    got = 0;
    while (!got && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) got = 1;
    end
    chk("latency", n, 3);
    chk("lat_data", out_data, expo);
  endtask

  task automatic backpressure();
    logic [23:0] bp[5];
    int acc, x0;
    for (int i = 0; i < 5; i++) bp[i] = 24'($urandom);
    acc = 0;
    x0  = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = (c >= 8);
      in_valid  = (acc < 5);
      in_data   = bp[acc < 5 ? acc : 4];
      #1;
      if (c == 6) begin
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_accepted", acc, 3);
        chk("bp_full_valid", out_valid, 1);
      end
      if (c == 8) x0 = out_xfers;
      if (c == 13) chk("bp_drain_count", out_xfers - x0, 5);
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", acc, 5);
    chk("bp_queue_empty", exp_q.size(), 0);
  endtask

  task automatic reset_mid_stream();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 24'h808080;
    @(negedge clk);
    in_data   = 24'h40C020;
    @(negedge clk);
    in_valid  = 1'b0;
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_in_ready", in_ready, 1);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    lat_beat(24'hFFFFFF, 24'hFF79FF);
    idle(2);
    #3;
    chk("post_rst_sat", sat_count, SAT_EN ? 32'd2 : 32'd0);
  endtask

  task automatic ready_rand();
    while (rand_run) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    out_ready = 1'b1;
  endtask

  task automatic drive_rand();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(24'($urandom));
    end
    idle(1);
    rand_run = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    out_xfers = 0;
    rand_run  = 1'b1;
    clear_model();

    chk("model_grey", model(24'h808080), 26'h0808080);
    chk("model_white", model(24'hFFFFFF), 26'h2FF79FF);
    chk("model_black", model(24'h000000), 26'h2008700);
    chk("model_red", model(24'hFF8000), 26'h10000B2);

    #12;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_sat_count", sat_count, 0);
    chk("reset_in_ready", in_ready, 1);

    lat_beat(24'h808080, 24'h808080);
    send(24'h000000);
    send(24'hFF8000);
    idle(6);
    #3;
    chk("dir_sat_3", sat_count, SAT_EN ? 32'd3 : 32'd0);
    send(24'hFFFFFF);
    idle(6);
    #3;
    chk("dir_sat_5", sat_count, SAT_EN ? 32'd5 : 32'd0);

    backpressure();
    idle(4);
    reset_mid_stream();
    idle(4);

    fork
      ready_rand();
      drive_rand();
    join
    idle(12);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
